// File: rtl/usb_cmd_arb.sv
// usb_cmd_arb
//   Round-robin packet arbiter sharing the USB command FIFO write port among
//   NUM_REQ byte-stream requesters. Each granted packet is prefixed with a
//   header byte {4'hA, 1'b0, grant_id} so the host can demultiplex sources.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  idle cycles tolerated mid-packet before forced release
//            (only used when USB_ARB_TIMEOUT_EN is defined)
//
// Optional feature macro: USB_ARB_TIMEOUT_EN
//   Defined   : mid-packet idle counter; on expiry writes 8'hEE, pulses
//               timeout and releases the grant.
//   Undefined : no counter, timeout tied low, grant held until req_last.
//
// Ports
//   clk               system clock (FIFO write-side clock)
//   rst               asynchronous active-high reset
//   req_valid/data/last  per-requester byte stream, byte i at [8i+7:8i]
//   req_ready         per-requester accept (combinational)
//   fifo_almost_full  FIFO backpressure
//   fifo_wr_en/din    registered FIFO write port
//   grant_id          current or last granted requester
//   busy              high when not in IDLE
//   pkt_cnt           completed packet count (wraps)
//   timeout           one-cycle pulse on forced release
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | scanning req_valid from prio_ptr for the next requester
// HDR   | granted; waiting for FIFO room to write the header byte
// DATA  | streaming granted requester's bytes until req_last
module usb_cmd_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_almost_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_din,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          pkt_cnt,
  output logic                 timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("usb_cmd_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_prio_ptr, w_prio_nxt;
  logic [2:0]  r_grant_id, w_grant_nxt;
  logic        r_wr_en, w_wr_en_nxt;
  logic [7:0]  r_din, w_din_nxt;
  logic [15:0] r_pkt_cnt, w_pkt_nxt;

  logic        w_sel_valid;
  logic        w_sel_last;
  logic [7:0]  w_sel_data;
  logic        w_scan_found;
  logic [2:0]  w_scan_idx;
  logic [2:0]  w_grant_inc;
  logic        w_hs;

`ifdef USB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  // Granted requester's stream.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Rotating priority: indices below prio_ptr are considered first so that
  // the second pass (indices at or above prio_ptr) overrides them; each pass
  // runs downward so the lowest matching index wins within a pass.
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_idx   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (3'(i) < r_prio_ptr)) begin
        w_scan_found = 1'b1;
        w_scan_idx   = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (3'(i) >= r_prio_ptr)) begin
        w_scan_found = 1'b1;
        w_scan_idx   = 3'(i);
      end
    end
  end

  assign w_grant_inc = (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
  assign w_hs        = (r_state == S_DATA) && w_sel_valid && !fifo_almost_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_hs && (r_grant_id == 3'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio_ptr;
    w_grant_nxt = r_grant_id;
    w_wr_en_nxt = 1'b0;
    w_din_nxt   = r_din;
    w_pkt_nxt   = r_pkt_cnt;
`ifdef USB_ARB_TIMEOUT_EN
    w_to_nxt      = r_to_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_scan_found) begin
          w_grant_nxt = w_scan_idx;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        if (!fifo_almost_full) begin
          w_wr_en_nxt = 1'b1;
          w_din_nxt   = {4'hA, 1'b0, r_grant_id};
          w_state_nxt = S_DATA;
`ifdef USB_ARB_TIMEOUT_EN
          w_to_nxt    = '0;
`endif
        end
      end
      S_DATA: begin
        if (w_hs) begin
          w_wr_en_nxt = 1'b1;
          w_din_nxt   = w_sel_data;
`ifdef USB_ARB_TIMEOUT_EN
          w_to_nxt    = '0;
`endif
          if (w_sel_last) begin
            w_state_nxt = S_IDLE;
            w_prio_nxt  = w_grant_inc;
            w_pkt_nxt   = r_pkt_cnt + 16'd1;
          end
        end
`ifdef USB_ARB_TIMEOUT_EN
        // Only requester silence counts; almost_full stalls freeze the count.
        else if (!w_sel_valid && !fifo_almost_full) begin
          if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            w_wr_en_nxt   = 1'b1;
            w_din_nxt     = 8'hEE;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
            w_prio_nxt    = w_grant_inc;
            w_to_nxt      = '0;
          end else begin
            w_to_nxt = r_to_cnt + TO_W'(1);
          end
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prio_ptr <= 3'd0;
      r_grant_id <= 3'd0;
      r_wr_en    <= 1'b0;
      r_din      <= 8'h00;
      r_pkt_cnt  <= 16'd0;
`ifdef USB_ARB_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_prio_ptr <= w_prio_nxt;
      r_grant_id <= w_grant_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_din      <= w_din_nxt;
      r_pkt_cnt  <= w_pkt_nxt;
`ifdef USB_ARB_TIMEOUT_EN
      r_to_cnt   <= w_to_nxt;
      r_timeout  <= w_timeout_nxt;
`endif
    end
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_din   = r_din;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != S_IDLE);
  assign pkt_cnt    = r_pkt_cnt;
`ifdef USB_ARB_TIMEOUT_EN
  assign timeout    = r_timeout;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_usb_cmd_arb.sv
module tb_usb_cmd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_almost_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [2:0]  grant_id;
  logic        busy;
  logic [15:0] pkt_cnt;
  logic        timeout;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int base;

  logic [7:0] q[$];

  usb_cmd_arb #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_din         (fifo_din),
    .grant_id         (grant_id),
    .busy             (busy),
    .pkt_cnt          (pkt_cnt),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && fifo_wr_en) q.push_back(fifo_din);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int idx, input logic [7:0] e);
    logic [31:0] obs;
    obs = (idx < q.size()) ? {24'h0, q[idx]} : 32'hFFFF_FFFF;
    check(tag, obs, {24'h0, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte on requester r and return 1 time unit after the edge
  // on which it was accepted; valid/last are dropped on return.
  task automatic put_byte(input int r, input logic [7:0] d, input bit last);
    int k;
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r] = last;
    #1;
    k = 0;
    while (!req_ready[r] && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("ready_wait", {31'h0, req_ready[r]}, 32'h1);
    tick();
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"},  {31'h0, fifo_wr_en}, 32'h0);
    check({tag, "_din"},    {24'h0, fifo_din},   32'h0);
    check({tag, "_busy"},   {31'h0, busy},       32'h0);
    check({tag, "_pkt"},    {16'h0, pkt_cnt},    32'h0);
    check({tag, "_to"},     {31'h0, timeout},    32'h0);
    check({tag, "_ready"},  {28'h0, req_ready},  32'h0);
    check({tag, "_gid"},    {29'h0, grant_id},   32'h0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    fifo_almost_full = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Single packet from requester 2: A2 11 22 33, with exact latency.
    base = q.size();
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h11;
    req_last[2] = 1'b0;
    tick();
    check("t1_hdr_busy",  {31'h0, busy},       32'h1);
    check("t1_hdr_gid",   {29'h0, grant_id},   32'h2);
    check("t1_hdr_wr",    {31'h0, fifo_wr_en}, 32'h0);
    check("t1_hdr_ready", {28'h0, req_ready},  32'h0);
    tick();
    check("t1_h_wr",    {31'h0, fifo_wr_en}, 32'h1);
    check("t1_h_din",   {24'h0, fifo_din},   32'hA2);
    check("t1_d_ready", {28'h0, req_ready},  32'h4);
    tick();
    check("t1_b0_din", {24'h0, fifo_din}, 32'h11);
    put_byte(2, 8'h22, 1'b0);
    put_byte(2, 8'h33, 1'b1);
    check("t1_end_busy", {31'h0, busy},     32'h0);
    check("t1_end_din",  {24'h0, fifo_din}, 32'h33);
    tick();
    check("t1_post_wr", {31'h0, fifo_wr_en}, 32'h0);
    check("t1_pkt",     {16'h0, pkt_cnt},    32'h1);
    check("t1_qlen", q.size() - base, 32'd4);
    check_q("t1_q0", base + 0, 8'hA2);
    check_q("t1_q1", base + 1, 8'h11);
    check_q("t1_q2", base + 2, 8'h22);
    check_q("t1_q3", base + 3, 8'h33);

    // Minimum packet with header held by almost_full; prio_ptr is 3 so
    // requester 1 is found after wrapping.
    base = q.size();
    fifo_almost_full = 1'b1;
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h55;
    req_last[1] = 1'b1;
    tick();
    tick();
    tick();
    check("t2_hold_gid",  {29'h0, grant_id},   32'h1);
    check("t2_hold_wr",   {31'h0, fifo_wr_en}, 32'h0);
    check("t2_hold_busy", {31'h0, busy},       32'h1);
    fifo_almost_full = 1'b0;
    put_byte(1, 8'h55, 1'b1);
    tick();
    check("t2_pkt",  {16'h0, pkt_cnt}, 32'h2);
    check("t2_qlen", q.size() - base, 32'd2);
    check_q("t2_q0", base + 0, 8'hA1);
    check_q("t2_q1", base + 1, 8'h55);

    // Backpressure mid-packet on requester 0 (prio_ptr is 2).
    base = q.size();
    put_byte(0, 8'h01, 1'b0);
    put_byte(0, 8'h02, 1'b0);
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h03;
    fifo_almost_full = 1'b1;
    #1;
    check("t3_af_ready",  {28'h0, req_ready},  32'h0);
    check("t3_inflight",  {31'h0, fifo_wr_en}, 32'h1);
    check("t3_inflight_d", {24'h0, fifo_din},  32'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_wr",    {31'h0, fifo_wr_en}, 32'h0);
      check("t3_stall_ready", {28'h0, req_ready},  32'h0);
    end
    fifo_almost_full = 1'b0;
    put_byte(0, 8'h03, 1'b0);
    put_byte(0, 8'h04, 1'b0);
    put_byte(0, 8'h05, 1'b1);
    tick();
    check("t3_pkt",  {16'h0, pkt_cnt}, 32'h3);
    check("t3_qlen", q.size() - base, 32'd6);
    check_q("t3_q0", base + 0, 8'hA0);
    check_q("t3_q1", base + 1, 8'h01);
    check_q("t3_q2", base + 2, 8'h02);
    check_q("t3_q3", base + 3, 8'h03);
    check_q("t3_q4", base + 4, 8'h04);
    check_q("t3_q5", base + 5, 8'h05);

    // Reset mid-packet: requester 3 (prio_ptr 1) after header and one byte.
    put_byte(3, 8'h66, 1'b0);
    check("t4_pre_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_reset_vals("t4_rst");
    tick();
    rst = 1'b0;
    tick();
    base = q.size();
    put_byte(3, 8'h77, 1'b1);
    tick();
    check("t4_pkt",  {16'h0, pkt_cnt}, 32'h1);
    check("t4_qlen", q.size() - base, 32'd2);
    check_q("t4_q0", base + 0, 8'hA3);
    check_q("t4_q1", base + 1, 8'h77);

    // Round robin from prio_ptr 0 with all requesters holding 1-byte packets.
    base = q.size();
    req_valid = 4'hF;
    req_last  = 4'hF;
    req_data  = 32'h13121110;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (q.size() - base >= 10) break;
    end
    req_valid = '0;
    req_last  = '0;
    check("t5_enough", {31'h0, (q.size() - base) >= 10}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      check_q("t5_hdr",  base + 2*k,     8'hA0 | 8'(k % 4));
      check_q("t5_data", base + 2*k + 1, 8'h10 + 8'(k % 4));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // pkt_cnt wrap.
    force dut.r_pkt_cnt = 16'hFFFF;
    #1;
    release dut.r_pkt_cnt;
    #1;
    check("t6_pre", {16'h0, pkt_cnt}, 32'hFFFF);
    put_byte(0, 8'h99, 1'b1);
    check("t6_wrap", {16'h0, pkt_cnt}, 32'h0);
    tick();

`ifdef USB_ARB_TIMEOUT_EN
    // Timeout: requester 1 (prio_ptr 1) sends one byte then goes silent.
    put_byte(1, 8'h44, 1'b0);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h88;
    req_last[2] = 1'b1;
    for (int k = 1; k < 8; k++) tick();
    check("t7_pre_to",   {31'h0, timeout}, 32'h0);
    check("t7_pre_busy", {31'h0, busy},    32'h1);
    tick();
    check("t7_to",   {31'h0, timeout},    32'h1);
    check("t7_wr",   {31'h0, fifo_wr_en}, 32'h1);
    check("t7_din",  {24'h0, fifo_din},   32'hEE);
    check("t7_pkt",  {16'h0, pkt_cnt},    32'h0);
    tick();
    check("t7_to_once", {31'h0, timeout},  32'h0);
    check("t7_gid",     {29'h0, grant_id}, 32'h2);
    put_byte(2, 8'h88, 1'b1);
    check("t7_pkt2", {16'h0, pkt_cnt}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
